// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU that sits beside the core datapath for wide arithmetic.
// Binary, logic and shift operations finish one cycle after they are
// accepted; decimal (BCD) ADD/SUB walks the operands one 4-bit digit per
// cycle, least significant digit first, and finishes after WIDTH/4 cycles.
// The sequencer raises start, waits for the one-cycle done pulse, then reads
// result and flags, which hold until the next completion.
//
// Parameters
//   WIDTH   operand/result width, a multiple of 4 and at least 8
//   DEC_EN  1 enables decimal mode; 0 makes the decimal input a don't-care
//
// Ports
//   clk        clock, every register updates on the rising edge
//   rst        asynchronous active-high reset
//   start      request, sampled only while busy is low
//   op         000 ADD, 001 SUB, 010 AND, 011 EOR, 100 OR, 101 SHR,
//              110 SHL, 111 reserved (returns zero)
//   decimal    BCD mode for ADD/SUB
//   a_in       operand A
//   b_in       operand B
//   carry_in   carry in for ADD/SUB, fill bit for shifts
//   busy       operation in progress
//   done       one-cycle pulse, result and flags updated this cycle
//   result     registered result
//   carry_out  registered carry
//   overflow   registered signed overflow
//   zero       registered result == 0
//   negative   registered result MSB
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH  = 16,
   parameter bit DEC_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             decimal,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NDIG = WIDTH / 4;
   localparam int CW   = $clog2(NDIG);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_EOR = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BIN  = 2'b01,
      DEC  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t state, state_next;

   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic             dec_c;
   logic [CW-1:0]    digit_cnt;
   logic [WIDTH-5:0] acc;

   logic             accept;
   logic             dec_req;
   logic             last_digit;

   logic [WIDTH:0]   bin_sum;
   logic [WIDTH-1:0] bin_res;
   logic             bin_c;
   logic             bin_v;

   logic [4:0]       dig_sum;
   logic [4:0]       dig_adj;
   logic [3:0]       dig;
   logic             dig_c;
   logic [WIDTH-1:0] dec_final;

   // A request is taken in IDLE and also in DONE, so the sequencer can issue
   // back-to-back operations without an extra idle cycle. Decimal mode only
   // applies to ADD/SUB, which are the two opcodes with op[2:1] == 0.
   assign accept     = start && ((state == IDLE) || (state == DONE));
   assign dec_req    = DEC_EN && decimal && (op[2:1] == 2'b00);
   assign last_digit = (digit_cnt == CW'(NDIG - 1));

   assign busy = (state == BIN) || (state == DEC);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: binary ops take one cycle, decimal ops stay in DEC
   // until the last digit has been processed, DONE lasts exactly one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_next = dec_req ? DEC : BIN;
            end else begin
               state_next = IDLE;
            end
         end
         BIN:     state_next = DONE;
         DEC:     state_next = last_digit ? DONE : DEC;
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle datapath working on the latched operands. b_q already holds
   // the effective B (inverted for SUB), so ADD and SUB share one adder and
   // carry_in = 1 on SUB means "no borrow".
   always_comb begin
      bin_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
      bin_res = '0;
      bin_c   = 1'b0;
      bin_v   = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            bin_res = bin_sum[WIDTH-1:0];
            bin_c   = bin_sum[WIDTH];
            bin_v   = (a_q[WIDTH-1] ^ bin_sum[WIDTH-1]) &
                      (b_q[WIDTH-1] ^ bin_sum[WIDTH-1]);
         end
         OP_AND: bin_res = a_q & b_q;
         OP_EOR: bin_res = a_q ^ b_q;
         OP_OR:  bin_res = a_q | b_q;
         OP_SHR: begin
            bin_res = {cin_q, a_q[WIDTH-1:1]};
            bin_c   = a_q[0];
         end
         OP_SHL: begin
            bin_res = {a_q[WIDTH-2:0], cin_q};
            bin_c   = a_q[WIDTH-1];
         end
         default: begin
            bin_res = '0;
         end
      endcase
   end

   // One BCD digit step on the low nibble of the shifting operand registers.
   // ADD corrects sums above 9 by adding 6; SUB works on the nine's
   // complement-style ~B digit, so a sum below 16 means a borrow and is
   // corrected by adding 10. Non-BCD digits go through the same arithmetic.
   always_comb begin
      dig_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, dec_c};
      dig_adj = dig_sum;
      dig_c   = 1'b0;
      if (op_q == OP_SUB) begin
         if (dig_sum < 5'd16) begin
            dig_adj = dig_sum + 5'd10;
            dig_c   = 1'b0;
         end else begin
            dig_adj = dig_sum;
            dig_c   = 1'b1;
         end
      end else begin
         if (dig_sum > 5'd9) begin
            dig_adj = dig_sum + 5'd6;
            dig_c   = 1'b1;
         end else begin
            dig_adj = dig_sum;
            dig_c   = 1'b0;
         end
      end
      dig       = dig_adj[3:0];
      dec_final = {dig, acc};
   end

   // Operand latches and the digit-serial accumulator. Each new digit enters
   // at the top of acc so that, after the last step, {digit, acc} is the
   // complete result in the right order. Outputs only change on completion,
   // keeping partial decimal sums invisible to the sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         dec_c     <= 1'b0;
         digit_cnt <= '0;
         acc       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= op;
            a_q       <= a_in;
            b_q       <= (op == OP_SUB) ? ~b_in : b_in;
            cin_q     <= carry_in;
            dec_c     <= carry_in;
            digit_cnt <= '0;
            acc       <= '0;
         end else if (state == BIN) begin
            result    <= bin_res;
            carry_out <= bin_c;
            overflow  <= bin_v;
            zero      <= (bin_res == '0);
            negative  <= bin_res[WIDTH-1];
         end else if (state == DEC) begin
            a_q       <= a_q >> 4;
            b_q       <= b_q >> 4;
            dec_c     <= dig_c;
            acc       <= dec_final[WIDTH-1:4];
            digit_cnt <= digit_cnt + 1'b1;
            if (last_digit) begin
               result    <= dec_final;
               carry_out <= dig_c;
               overflow  <= 1'b0;
               zero      <= (dec_final == '0);
               negative  <= dec_final[WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq at WIDTH=16, DEC_EN=1. Each task
// drives one scenario and compares the DUT against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic          decimal;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          carry_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic          overflow;
   logic          zero;
   logic          negative;

   int checks;
   int errors;

   // Expected vector: operands plus the result and {C,V,Z,N} flags.
   typedef struct {
      logic [2:0]   op;
      logic         dec;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] res;
      logic [3:0]   cvzn;
      int           cyc;
   } vec_t;

   alu_seq #(.WIDTH(W), .DEC_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .decimal   (decimal),
      .a_in      (a_in),
      .b_in      (b_in),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where inputs are driven and
   // outputs are sampled.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge with the given operands, then count edges until
   // done shows up. cyc is -1 if done never arrives within the budget.
   task automatic run_op(input logic [2:0] o, input logic d, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c, output int cyc);
      op       = o;
      decimal  = d;
      a_in     = a;
      b_in     = b;
      carry_in = c;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   // Run a table of vectors, checking result/flags and completion latency.
   task automatic run_table(input string name, input vec_t v[]);
      int cyc;
      for (int i = 0; i < v.size(); i++) begin
         run_op(v[i].op, v[i].dec, v[i].a, v[i].b, v[i].cin, cyc);
         checks++;
         if ({result, carry_out, overflow, zero, negative} !== {v[i].res, v[i].cvzn}) begin
            errors++;
            $display("[TB] FAIL %s[%0d] result/CVZN: got %h/%b expected %h/%b", name, i,
                     result, {carry_out, overflow, zero, negative}, v[i].res, v[i].cvzn);
         end
         checks++;
         if (cyc !== v[i].cyc) begin
            errors++;
            $display("[TB] FAIL %s[%0d] latency: got %0d expected %0d", name, i, cyc, v[i].cyc);
         end
      end
   endtask

   // Everything must read zero while reset is held.
   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, result, carry_out, overflow, zero, negative} !== '0) begin
         errors++;
         $display("[TB] FAIL reset outputs: got %b/%b/%h/%b expected 0/0/0000/0000", busy, done,
                  result, {carry_out, overflow, zero, negative});
      end
      rst = 1'b0;
      tick();
   endtask

   // Binary ADD/SUB including signed overflow and carry/borrow.
   task automatic test_binary_arith;
      vec_t v[] = '{
         '{3'b000, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101, 1},
         '{3'b001, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0001, 1},
         '{3'b000, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010, 1},
         '{3'b001, 1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100, 1}
      };
      run_table("bin_arith", v);
   endtask

   // Digit-serial BCD ADD/SUB, each completing WIDTH/4 = 4 cycles after start.
   task automatic test_decimal;
      vec_t v[] = '{
         '{3'b000, 1'b1, 16'h0999, 16'h0001, 1'b0, 16'h1000, 4'b0000, 4},
         '{3'b000, 1'b1, 16'h9999, 16'h0001, 1'b0, 16'h0000, 4'b1010, 4},
         '{3'b001, 1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0999, 4'b1000, 4},
         '{3'b001, 1'b1, 16'h0000, 16'h0001, 1'b1, 16'h9999, 4'b0001, 4},
         '{3'b000, 1'b1, 16'h1234, 16'h5678, 1'b1, 16'h6913, 4'b0000, 4}
      };
      run_table("decimal", v);
   endtask

   // Logic ops, shifts with fill bit, reserved op, decimal ignored for AND.
   task automatic test_logic_shift;
      vec_t v[] = '{
         '{3'b101, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h8001, 4'b1001, 1},
         '{3'b110, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b1010, 1},
         '{3'b010, 1'b1, 16'hFF0F, 16'h0FF0, 1'b1, 16'h0F00, 4'b0000, 1},
         '{3'b011, 1'b0, 16'hFF0F, 16'h0FF0, 1'b0, 16'hF0FF, 4'b0001, 1},
         '{3'b100, 1'b0, 16'hFF0F, 16'h0FF0, 1'b0, 16'hFFFF, 4'b0001, 1},
         '{3'b110, 1'b0, 16'h4001, 16'h0000, 1'b1, 16'h8003, 4'b0001, 1},
         '{3'b111, 1'b0, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0010, 1}
      };
      run_table("logic_shift", v);
   endtask

   // busy rises after the accepting edge, done lasts one cycle, outputs hold.
   task automatic test_done_pulse;
      op       = 3'b000;
      decimal  = 1'b0;
      a_in     = 16'h0102;
      b_in     = 16'h0304;
      carry_in = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL busy_after_start: got busy/done %b%b expected 10", busy, done);
      end
      tick();
      checks++;
      if ({busy, done, result} !== {2'b01, 16'h0406}) begin
         errors++;
         $display("[TB] FAIL done_cycle: got %b%b/%h expected 01/0406", busy, done, result);
      end
      tick();
      checks++;
      if ({busy, done, result} !== {2'b00, 16'h0406}) begin
         errors++;
         $display("[TB] FAIL after_done: got %b%b/%h expected 00/0406", busy, done, result);
      end
   endtask

   // start while busy is ignored; start in the DONE cycle is accepted.
   task automatic test_back_to_back;
      int cyc;
      op       = 3'b000;
      decimal  = 1'b1;
      a_in     = 16'h0999;
      b_in     = 16'h0001;
      carry_in = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      op       = 3'b001;
      decimal  = 1'b0;
      a_in     = 16'h1234;
      b_in     = 16'h1111;
      carry_in = 1'b1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 2;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++;
      if (!done || cyc !== 4 || result !== 16'h1000 || carry_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignore_start: got done=%b cyc=%0d %h C=%b expected 1 4 1000 C=0",
                  done, cyc, result, carry_out);
      end
      run_op(3'b000, 1'b0, 16'h0005, 16'h0003, 1'b0, cyc);
      checks++;
      if (cyc !== 1 || result !== 16'h0008) begin
         errors++;
         $display("[TB] FAIL start_in_done: got cyc=%0d %h expected 1 0008", cyc, result);
      end
   endtask

   // Asynchronous reset in the middle of a decimal op clears outputs at once.
   task automatic test_reset_mid_op;
      int cyc;
      op       = 3'b000;
      decimal  = 1'b1;
      a_in     = 16'h9999;
      b_in     = 16'h0001;
      carry_in = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, result, carry_out, overflow, zero, negative} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_op: got %b%b/%h/%b expected 00/0000/0000", busy, done,
                  result, {carry_out, overflow, zero, negative});
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got busy/done %b%b expected 00", busy, done);
      end
      run_op(3'b000, 1'b0, 16'h0001, 16'h0001, 1'b0, cyc);
      checks++;
      if (cyc !== 1 || result !== 16'h0002 || {carry_out, overflow, zero, negative} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL add_after_reset: got cyc=%0d %h/%b expected 1 0002/0000", cyc,
                  result, {carry_out, overflow, zero, negative});
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      op       = 3'b000;
      decimal  = 1'b0;
      a_in     = '0;
      b_in     = '0;
      carry_in = 1'b0;
      test_reset();
      test_binary_arith();
      test_decimal();
      test_logic_shift();
      test_done_pulse();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
